// File: rtl/sr_btn_pkg.sv
// Shared definitions for the LED shift-register / button / SPI pad interface.
package sr_btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPI      = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_SENSE    = 3'd5,
    ST_PAUSE    = 3'd6
  } state_t;

  // Bit positions inside the {csn,clk,miso,mosi} pad bundles
  localparam int IDX_MOSI = 0;
  localparam int IDX_MISO = 1;
  localparam int IDX_CLK  = 2;
  localparam int IDX_CSN  = 3;

endpackage

// File: rtl/sr_btn_debounce.sv
// Button debouncer: btn value flips only after DEB_CNT consecutive raw
// decisions that disagree with it; emits one-cycle press/release pulses.
module sr_btn_debounce #(
  parameter int DEB_CNT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic raw_stb_i,
  output logic val_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [3:0] DEB_V = 4'(DEB_CNT);

  logic [3:0] cnt_q, cnt_d;
  logic       val_q, val_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;

  // Count disagreeing decisions; a matching decision restarts the count
  always_comb begin
    cnt_d   = cnt_q;
    val_d   = val_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (raw_stb_i) begin
      if (raw_i == val_q) begin
        cnt_d = '0;
      end else if ((cnt_q + 4'd1) >= DEB_V) begin
        cnt_d   = '0;
        val_d   = raw_i;
        press_d = raw_i;
        rel_d   = ~raw_i;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Debounce state and event registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      val_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign val_o     = val_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/sr_btn_if_gen.sv
// LED shift-register driver sharing the flash SPI pads, with RCLK-pad button
// sensing, debounce and periodic refresh of the last LED word.
module sr_btn_if_gen
  import sr_btn_pkg::*;
#(
  parameter int SR_WIDTH      = 16,
  parameter int MSB_FIRST     = 1,
  parameter int TICK_LOG2_DIV = 3,
  parameter int SENSE_LOG2    = 3,
  parameter int SENSE_THRESH  = 4,
  parameter int DEB_CNT       = 2,
  parameter int REFRESH_LOG2  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SR_WIDTH-1:0] sr_val,
  input  logic                sr_go,
  output logic                sr_rdy,
  input  logic                spi_req,
  output logic                spi_gnt,
  input  logic [3:0]          spi_o,
  input  logic [3:0]          spi_oe,
  output logic [2:0]          spi_i,
  output logic [3:0]          pad_o,
  output logic [3:0]          pad_oe,
  input  logic [2:0]          pad_i,
  output logic                rclk_o,
  output logic                rclk_oe,
  input  logic                rclk_i,
  output logic                btn_val,
  output logic                btn_stb,
  output logic                btn_press,
  output logic                btn_release
);

  localparam int TW = (TICK_LOG2_DIV > 0) ? TICK_LOG2_DIV : 1;
  localparam int BW = $clog2(SR_WIDTH + 1);
  localparam int HW = SENSE_LOG2 + 1;
  localparam int RW = (REFRESH_LOG2 > 0) ? REFRESH_LOG2 : 1;
  localparam logic [BW-1:0] BIT_LAST   = BW'(SR_WIDTH);
  localparam logic [HW-1:0] SENSE_LAST = HW'((1 << SENSE_LOG2) - 1);
  localparam logic [HW:0]   THRESH_V   = (HW + 1)'(SENSE_THRESH);

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic                tick, busy;
  logic [BW-1:0]       bit_q, bit_d;
  logic [HW-1:0]       scnt_q, scnt_d;
  logic [HW-1:0]       high_q, high_d;
  logic [SR_WIDTH-1:0] shift_q, shift_d, shift_adv;
  logic [SR_WIDTH-1:0] last_q, last_d;
  logic [RW-1:0]       ref_q;
  logic                pend_q, pend_d, ref_wrap, go_acc, ref_start;
  logic [1:0]          sync_q;
  logic                pclk_q, pclk_d, mosi_q, mosi_d, cur_bit;
  logic                rclk_o_q, rclk_o_d, rclk_oe_q, rclk_oe_d;
  logic                gnt_q, stb_q, raw, raw_stb;

  assign busy = (state_q != ST_IDLE) && (state_q != ST_SPI);
  assign tick = busy && ((TICK_LOG2_DIV == 0) || (tick_q == '1));
  assign tick_d = busy ? tick_q + 1'b1 : '0;

  assign shift_adv = (MSB_FIRST != 0) ? {shift_q[SR_WIDTH-2:0], 1'b0}
                                      : {1'b0, shift_q[SR_WIDTH-1:1]};
  assign cur_bit   = (MSB_FIRST != 0) ? shift_d[SR_WIDTH-1] : shift_d[0];

  assign ref_wrap = (REFRESH_LOG2 != 0) && (ref_q == '1);
  assign pend_d   = ref_wrap ? 1'b1 : ((go_acc || ref_start) ? 1'b0 : pend_q);

  assign raw_stb = (state_q == ST_PAUSE) && tick;
  assign raw     = ({1'b0, high_q} < THRESH_V);

  // Sequencer: next state, shift data and bit/sense counters
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    last_d    = last_q;
    bit_d     = bit_q;
    scnt_d    = scnt_q;
    high_d    = high_q;
    go_acc    = 1'b0;
    ref_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sr_go) begin
          go_acc  = 1'b1;
          shift_d = sr_val;
          last_d  = sr_val;
          bit_d   = '0;
          state_d = ST_SHIFT_LO;
        end else if (spi_req) begin
          state_d = ST_SPI;
        end else if (pend_q) begin
          ref_start = 1'b1;
          shift_d   = last_q;
          bit_d     = '0;
          state_d   = ST_SHIFT_LO;
        end
      end
      ST_SPI: if (!spi_req) state_d = ST_IDLE;
      ST_SHIFT_LO: begin
        if (tick) begin
          bit_d   = bit_q + 1'b1;
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          shift_d = shift_adv;
          state_d = (bit_q == BIT_LAST) ? ST_LATCH : ST_SHIFT_LO;
        end
      end
      ST_LATCH: begin
        scnt_d = '0;
        high_d = '0;
        if (tick) state_d = ST_SENSE;
      end
      ST_SENSE: begin
        if (tick) begin
          scnt_d = scnt_q + 1'b1;
          high_d = high_q + HW'(sync_q[1]);
          if (scnt_q == SENSE_LAST) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad drive derived from the upcoming state so pads line up with state_q
  always_comb begin
    pclk_d    = 1'b0;
    mosi_d    = 1'b0;
    rclk_o_d  = 1'b0;
    rclk_oe_d = 1'b1;
    case (state_d)
      ST_SHIFT_LO: mosi_d = cur_bit;
      ST_SHIFT_HI: begin
        mosi_d = cur_bit;
        pclk_d = 1'b1;
      end
      ST_LATCH: rclk_o_d = 1'b1;
      ST_SENSE: begin
        rclk_o_d  = 1'b1;
        rclk_oe_d = 1'b0;
      end
      ST_PAUSE: rclk_oe_d = 1'b0;
      default: ;
    endcase
  end

  // Control, counter and pad registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      scnt_q    <= '0;
      high_q    <= '0;
      last_q    <= '0;
      ref_q     <= '0;
      pend_q    <= 1'b0;
      sync_q    <= 2'b11;
      pclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      rclk_o_q  <= 1'b0;
      rclk_oe_q <= 1'b1;
      gnt_q     <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      scnt_q    <= scnt_d;
      high_q    <= high_d;
      last_q    <= last_d;
      ref_q     <= ref_q + 1'b1;
      pend_q    <= pend_d;
      sync_q    <= {sync_q[0], rclk_i};
      pclk_q    <= pclk_d;
      mosi_q    <= mosi_d;
      rclk_o_q  <= rclk_o_d;
      rclk_oe_q <= rclk_oe_d;
      gnt_q     <= (state_d == ST_SPI);
      stb_q     <= raw_stb;
    end
  end

  // Shift data register; its content is don't-care until loaded in IDLE
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Pad mux: SPI core owns the pads while granted, csn always driven
  always_comb begin
    pad_o  = '0;
    pad_oe = '0;
    if (gnt_q) begin
      pad_o           = spi_o;
      pad_oe          = spi_oe;
      pad_oe[IDX_CSN] = 1'b1;
    end else begin
      pad_o[IDX_CSN]   = 1'b1;
      pad_o[IDX_CLK]   = pclk_q;
      pad_o[IDX_MOSI]  = mosi_q;
      pad_oe[IDX_CSN]  = 1'b1;
      pad_oe[IDX_CLK]  = 1'b1;
      pad_oe[IDX_MOSI] = 1'b1;
    end
  end

  assign spi_i   = pad_i;
  assign spi_gnt = gnt_q;
  assign sr_rdy  = (state_q == ST_IDLE);
  assign rclk_o  = rclk_o_q;
  assign rclk_oe = rclk_oe_q;
  assign btn_stb = stb_q;

  sr_btn_debounce #(
    .DEB_CNT(DEB_CNT)
  ) u_deb (
    .clk       (clk),
    .rst       (rst),
    .raw_i     (raw),
    .raw_stb_i (raw_stb),
    .val_o     (btn_val),
    .press_o   (btn_press),
    .release_o (btn_release)
  );

endmodule

// File: tb/tb_sr_btn_if_gen.sv
// Directed bench: u0 uses default parameters, u1 is LSB-first with a short
// refresh period.
module tb_sr_btn_if_gen;
  import sr_btn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] sr_val0 = '0, sr_val1 = '0;
  logic sr_go0 = 1'b0, sr_go1 = 1'b0, spi_req0 = 1'b0;
  logic [3:0] spi_o0 = '0, spi_oe0 = '0;
  logic [2:0] pad_i0 = 3'b101;
  logic rclk0_i = 1'b1, rclk1_i = 1'b1;
  logic rdy0, gnt0, rclk_o0, rclk_oe0, val0, stb0, press0, rel0;
  logic rdy1, gnt1, rclk_o1, rclk_oe1, val1, stb1, press1, rel1;
  logic [2:0] spi_i0, spi_i1;
  logic [3:0] pad_o0, pad_oe0, pad_o1, pad_oe1;

  sr_btn_if_gen u0 (
    .clk(clk), .rst(rst), .sr_val(sr_val0), .sr_go(sr_go0), .sr_rdy(rdy0),
    .spi_req(spi_req0), .spi_gnt(gnt0), .spi_o(spi_o0), .spi_oe(spi_oe0),
    .spi_i(spi_i0), .pad_o(pad_o0), .pad_oe(pad_oe0), .pad_i(pad_i0),
    .rclk_o(rclk_o0), .rclk_oe(rclk_oe0), .rclk_i(rclk0_i), .btn_val(val0),
    .btn_stb(stb0), .btn_press(press0), .btn_release(rel0)
  );

  sr_btn_if_gen #(.MSB_FIRST(0), .REFRESH_LOG2(8)) u1 (
    .clk(clk), .rst(rst), .sr_val(sr_val1), .sr_go(sr_go1), .sr_rdy(rdy1),
    .spi_req(1'b0), .spi_gnt(gnt1), .spi_o(4'b0000), .spi_oe(4'b0000),
    .spi_i(spi_i1), .pad_o(pad_o1), .pad_oe(pad_oe1), .pad_i(3'b000),
    .rclk_o(rclk_o1), .rclk_oe(rclk_oe1), .rclk_i(rclk1_i), .btn_val(val1),
    .btn_stb(stb1), .btn_press(press1), .btn_release(rel1)
  );

  // Monitor selection: 0 watches u0, 1 watches u1
  logic sel = 1'b0;
  wire m_clk   = sel ? pad_o1[IDX_CLK]  : pad_o0[IDX_CLK];
  wire m_mosi  = sel ? pad_o1[IDX_MOSI] : pad_o0[IDX_MOSI];
  wire m_rdy   = sel ? rdy1     : rdy0;
  wire m_ro    = sel ? rclk_o1  : rclk_o0;
  wire m_roe   = sel ? rclk_oe1 : rclk_oe0;
  wire m_stb   = sel ? stb1     : stb0;
  wire m_val   = sel ? val1     : val0;
  wire m_press = sel ? press1   : press0;
  wire m_rel   = sel ? rel1     : rel0;
  wire m_gnt   = sel ? gnt1     : gnt0;

  // Button pad model for u0: bit k of sense_pat is the level in sense tick window k
  logic [7:0] sense_pat = 8'hFF;
  int spos = 0;
  always @(negedge clk) begin
    if (rclk_o0 && !rclk_oe0) begin
      rclk0_i = sense_pat[(spos / 8) % 8];
      spos = spos + 1;
    end else begin
      rclk0_i = 1'b1;
      spos = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Follows one full shift/latch/sense sequence of the selected instance
  task automatic capture(output logic [31:0] seq, output int rclk_hi, output int lat,
                         output int stbs, output logic val_stb, output int presses,
                         output int releases, output int gnt_hi, output bit tmo);
    int nb = 0;
    int cyc = 0;
    int last = 0;
    bit done = 0;
    logic prev_clk;
    seq = '0; rclk_hi = 0; lat = 0; stbs = 0; val_stb = 1'b0;
    presses = 0; releases = 0; gnt_hi = 0; tmo = 0;
    prev_clk = m_clk;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (m_clk && !prev_clk) begin
        if (nb < 32) seq[nb] = m_mosi;
        nb++;
        last = cyc;
      end
      prev_clk = m_clk;
      if (m_ro && m_roe) rclk_hi++;
      if (m_stb) begin stbs++; val_stb = m_val; end
      if (m_press) presses++;
      if (m_rel) releases++;
      if (m_gnt) gnt_hi++;
      if (nb >= 16 && m_rdy) begin lat = cyc - last; done = 1; end
      if (cyc > 5000) begin tmo = 1; done = 1; end
    end
  endtask

  task automatic launch0(input logic [15:0] v);
    @(negedge clk);
    sr_val0 = v; sr_go0 = 1'b1;
    @(negedge clk);
    sr_go0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy0); end
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt0); end
    checks++; if (pad_o0 !== 4'b1000) begin errors++; $display("FAIL reset_pad_o: got %b want 1000", pad_o0); end
    checks++; if (pad_oe0 !== 4'b1101) begin errors++; $display("FAIL reset_pad_oe: got %b want 1101", pad_oe0); end
    checks++; if ({rclk_o0, rclk_oe0} !== 2'b01) begin errors++; $display("FAIL reset_rclk: got %b want 01", {rclk_o0, rclk_oe0}); end
    checks++; if ({val0, stb0, press0, rel0} !== 4'b0000) begin errors++; $display("FAIL reset_btn: got %b want 0000", {val0, stb0, press0, rel0}); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_rdy1: got %b want 1", rdy1); end
    rst = 1'b0;
  endtask

  task automatic test_bit_order_refresh();
    logic [31:0] seq; int rh, lat, stbs, pr, rl, gh; logic vs; bit tmo;
    sel = 1'b1;
    @(negedge clk);
    sr_val1 = 16'h0001; sr_go1 = 1'b1;
    @(negedge clk);
    sr_go1 = 1'b0;
    capture(seq, rh, lat, stbs, vs, pr, rl, gh, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL lsb_timeout: got timeout want completion"); end
    checks++; if (seq[15:0] !== 16'h0001) begin errors++; $display("FAIL lsb_bits: got %h want 0001", seq[15:0]); end
    // refresh became pending during that shift and replays sr_last
    capture(seq, rh, lat, stbs, vs, pr, rl, gh, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL refresh_timeout: got timeout want completion"); end
    checks++; if (seq[15:0] !== 16'h0001) begin errors++; $display("FAIL refresh_bits: got %h want 0001", seq[15:0]); end
    sel = 1'b0;
  endtask

  task automatic test_shift();
    logic [31:0] seq; int rh, lat, stbs, pr, rl, gh, lowc; logic vs; bit tmo;
    sel = 1'b0;
    launch0(16'hA5C3);
    repeat (2) @(negedge clk);
    sr_val0 = 16'hFFFF; sr_go0 = 1'b1;
    @(negedge clk);
    sr_go0 = 1'b0;
    capture(seq, rh, lat, stbs, vs, pr, rl, gh, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL shift_timeout: got timeout want completion"); end
    checks++; if (seq[15:0] !== 16'hC3A5) begin errors++; $display("FAIL shift_bits: got %h want c3a5", seq[15:0]); end
    checks++; if (rh !== 8) begin errors++; $display("FAIL latch_len: got %0d want 8", rh); end
    checks++; if (lat !== 88) begin errors++; $display("FAIL rdy_latency: got %0d want 88", lat); end
    checks++; if (stbs !== 1 || vs !== 1'b0) begin errors++; $display("FAIL shift_stb: got %0d/%b want 1/0", stbs, vs); end
    lowc = 0;
    repeat (30) begin @(negedge clk); if (!rdy0) lowc++; end
    checks++; if (lowc !== 0) begin errors++; $display("FAIL busy_go_queued: got %0d busy cycles want 0", lowc); end
  endtask

  task automatic run_button(input string nm, input logic [7:0] pats [4], input logic [3:0] ev,
                            input logic [3:0] ep, input logic [3:0] er);
    logic [31:0] seq; int rh, lat, stbs, pr, rl, gh; logic vs; bit tmo;
    for (int i = 0; i < 4; i++) begin
      sense_pat = pats[i];
      launch0(16'h0000);
      capture(seq, rh, lat, stbs, vs, pr, rl, gh, tmo);
      checks++; if (tmo || stbs !== 1) begin errors++; $display("FAIL %s_stb%0d: got %0d strobes want 1", nm, i, stbs); end
      checks++; if (vs !== ev[i]) begin errors++; $display("FAIL %s_val%0d: got %b want %b", nm, i, vs, ev[i]); end
      checks++; if (pr !== int'(ep[i]) || rl !== int'(er[i])) begin errors++; $display("FAIL %s_evt%0d: got press=%0d release=%0d want %b/%b", nm, i, pr, rl, ep[i], er[i]); end
    end
  endtask

  task automatic test_button();
    logic [7:0] p [4];
    p = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    run_button("button", p, 4'b0110, 4'b0010, 4'b1000);
  endtask

  task automatic test_threshold();
    logic [7:0] p [4];
    p = '{8'h0F, 8'h0F, 8'h07, 8'h07};
    run_button("thresh", p, 4'b1000, 4'b1000, 4'b0000);
  endtask

  task automatic test_arbitration();
    logic [31:0] seq; int rh, lat, stbs, pr, rl, gh; logic vs; bit tmo;
    sense_pat = 8'h07;
    spi_o0 = 4'b0110; spi_oe0 = 4'b0010;
    @(negedge clk);
    sr_val0 = 16'h1234; sr_go0 = 1'b1; spi_req0 = 1'b1;
    @(negedge clk);
    sr_go0 = 1'b0;
    capture(seq, rh, lat, stbs, vs, pr, rl, gh, tmo);
    checks++; if (tmo || seq[15:0] !== 16'h2C48) begin errors++; $display("FAIL arb_shift: got %h want 2c48", seq[15:0]); end
    checks++; if (gh !== 0) begin errors++; $display("FAIL arb_gnt_during_shift: got %0d cycles want 0", gh); end
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1 || rdy0 !== 1'b0) begin errors++; $display("FAIL arb_gnt_rise: got gnt=%b rdy=%b want 1/0", gnt0, rdy0); end
    checks++; if (pad_o0 !== 4'b0110 || pad_oe0 !== 4'b1010) begin errors++; $display("FAIL arb_pad_mux: got %b/%b want 0110/1010", pad_o0, pad_oe0); end
    checks++; if (spi_i0 !== 3'b101) begin errors++; $display("FAIL arb_spi_i: got %b want 101", spi_i0); end
    spi_req0 = 1'b0;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL arb_gnt_fall: got %b want 0", gnt0); end
    checks++; if (pad_o0 !== 4'b1000 || pad_oe0 !== 4'b1101) begin errors++; $display("FAIL arb_pad_release: got %b/%b want 1000/1101", pad_o0, pad_oe0); end
  endtask

  task automatic test_reset_mid_shift();
    int n = 0;
    int hi = 0;
    int lowc = 0;
    checks++; if (val0 !== 1'b1) begin errors++; $display("FAIL pre_reset_val: got %b want 1", val0); end
    launch0(16'hFFFF);
    while (pad_o0[IDX_CLK] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL mid_shift_reach: got no pad clk high want high"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rdy0 !== 1'b1 || pad_o0[IDX_CLK] !== 1'b0 || pad_o0[IDX_CSN] !== 1'b1) begin errors++; $display("FAIL mid_reset_pads: got rdy=%b pad_o=%b want 1/1000", rdy0, pad_o0); end
    checks++; if (val0 !== 1'b0 || {rclk_o0, rclk_oe0} !== 2'b01) begin errors++; $display("FAIL mid_reset_btn: got val=%b rclk=%b%b want 0/01", val0, rclk_o0, rclk_oe0); end
    repeat (120) begin @(negedge clk); if (rclk_o0) hi++; if (!rdy0) lowc++; end
    checks++; if (hi !== 0 || lowc !== 0) begin errors++; $display("FAIL mid_reset_latch: got %0d latch/%0d busy cycles want 0/0", hi, lowc); end
  endtask

  task automatic test_refresh_period();
    logic [31:0] seq; int rh, lat, stbs, pr, rl, gh; logic vs; bit tmo;
    int n = 0;
    int busy0 = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    while (rdy1 === 1'b1 && n < 400) begin @(negedge clk); n++; if (!rdy0) busy0++; end
    checks++; if (n < 250 || n > 262) begin errors++; $display("FAIL refresh_period: got %0d cycles want about 257", n); end
    checks++; if (busy0 !== 0) begin errors++; $display("FAIL no_refresh_u0: got %0d busy cycles want 0", busy0); end
    sel = 1'b1;
    capture(seq, rh, lat, stbs, vs, pr, rl, gh, tmo);
    sel = 1'b0;
    checks++; if (tmo || seq[15:0] !== 16'h0000) begin errors++; $display("FAIL refresh_reset_word: got %h want 0000", seq[15:0]); end
  endtask

  initial begin
    test_reset();
    test_bit_order_refresh();
    test_shift();
    test_button();
    test_threshold();
    test_arbitration();
    test_reset_mid_shift();
    test_refresh_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_btn_if_gen.md
Name: sr_btn_if_gen

Overview:
Parametrised next-generation shift-register + button + shared-SPI pad interface for the icE1usb LED/button chain. It shifts an SR_WIDTH-bit LED word out on the flash MOSI/CLK pads and pulses the shared RCLK pad to latch it. It then releases RCLK to sense the button through the pull-up, and arbitrates the pads with the SPI core. New over the previous generation: generic width and bit order, configurable sense window and threshold, debounced button with press/release events, autonomous periodic refresh, and pad-level o/oe/i ports (SB_IO instantiation moves to the top level).

Parameters:
SR_WIDTH, 16, shift register length in bits (2..32).
MSB_FIRST, 1, 1: sr_val[SR_WIDTH-1] shifted first; 0: sr_val[0] first.
TICK_LOG2_DIV, 3, tick period = 2^TICK_LOG2_DIV clk cycles.
SENSE_LOG2, 3, number of sense samples = 2^SENSE_LOG2.
SENSE_THRESH, 4, raw "pressed" when the count of high samples < SENSE_THRESH.
DEB_CNT, 2, consecutive identical raw decisions required to change btn_val (1..15).
REFRESH_LOG2, 16, auto refresh every 2^REFRESH_LOG2 cycles; 0 disables refresh.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
sr_val  in  SR_WIDTH  word to shift.
sr_go  in  1  start request; accepted only when sr_rdy=1.
sr_rdy  out  1  high when state is IDLE.
spi_req  in  1  SPI core requests the pads.
spi_gnt  out  1  pads muxed to the SPI core.
spi_o  in  4  SPI core outputs {csn,clk,miso,mosi}.
spi_oe  in  4  SPI core output enables, same order.
spi_i  out  3  pad inputs to the SPI core {clk,miso,mosi}.
pad_o  out  4  pad outputs {csn,clk,miso,mosi}.
pad_oe  out  4  pad output enables; csn bit is always 1.
pad_i  in  3  pad inputs {clk,miso,mosi}.
rclk_o, rclk_oe  out  1  RCLK/button pad drive.
rclk_i  in  1  RCLK/button pad input; pulled up, button pulls low.
btn_val  out  1  debounced button state, 1 = pressed.
btn_stb  out  1  one-cycle pulse per completed sense cycle.
btn_press, btn_release  out  1  one-cycle pulses on debounced edges.

Behaviour:
- States: IDLE, SPI, SHIFT_LO, SHIFT_HI, LATCH, SENSE, PAUSE.
- Tick counter runs only outside IDLE and SPI. It is zeroed in those states. The first tick occurs 2^TICK_LOG2_DIV cycles after leaving IDLE; ticks then repeat every 2^TICK_LOG2_DIV cycles.
- IDLE priority, same cycle: sr_go > spi_req > pending refresh.
  - sr_go: loads sr_val into shift and sr_last, then goes to SHIFT_LO.
  - Refresh: reloads sr_last, then goes to SHIFT_LO.
- SPI: exits to IDLE the cycle after spi_req=0. spi_gnt is registered from state_nxt==SPI, so it rises 1 cycle after the request and falls 1 cycle after the release.
- SHIFT_LO -> SHIFT_HI -> SHIFT_LO, one tick each.
  - Bit counter increments on tick in SHIFT_LO.
  - After SR_WIDTH HI phases, SHIFT_HI goes to LATCH.
  - Shift register advances on tick in SHIFT_HI.
- LATCH (1 tick) -> SENSE (2^SENSE_LOG2 ticks) -> PAUSE (1 tick) -> IDLE.
- Pad outputs are registered from state:
  - SHIFT_*: mosi = current bit; clk = 0 in LO, 1 in HI.
  - LATCH: rclk_o=1, rclk_oe=1.
  - SENSE: rclk_o=1, rclk_oe=0.
  - PAUSE: rclk_o=0, rclk_oe=0.
  - All other states: rclk_o=0, rclk_oe=1.
- Non-SPI pad defaults: csn=1, clk oe=1, mosi oe=1, miso oe=0.
- rclk_i passes through a 2-flop synchronizer. On each tick in SENSE, the synchronized value is added to a SENSE_LOG2+1-bit counter, which is cleared in LATCH.
- Raw decision: on PAUSE tick, raw = (high_cnt < SENSE_THRESH).
  - Debounce counter is 4 bits. It counts consecutive raw values differing from btn_val and clears on a match.
  - When it reaches DEB_CNT, btn_val flips and btn_press or btn_release pulses on the same cycle as btn_stb.
  - btn_stb = registered (PAUSE & tick).
- Refresh counter is free-running and wraps. On wrap it sets refresh_pend, which is cleared when a refresh starts or when sr_go is accepted.
- Reset values:
  - state IDLE, spi_gnt 0.
  - pads at non-SPI defaults; rclk_o=0, rclk_oe=1.
  - btn_val, btn_stb, btn_press, btn_release = 0.
  - sr_last = 0; debounce counter, sense counters and refresh counter = 0.
- Reset mid-shift: aborts to IDLE with no partial latch, and pads return to defaults on the next cycle.
- sr_go while sr_rdy=0 is ignored, not queued.

Decomposition:
- Shared package sr_btn_pkg holds:
  - state encoding localparams;
  - bundle bit indices IDX_MOSI=0, IDX_MISO=1, IDX_CLK=2, IDX_CSN=3.
- One sub-module, sr_btn_debounce (params DEB_CNT; ins raw, raw_stb; outs val, press, release), instantiated once.

Test Plan:
- Shift: SR_WIDTH=16, MSB_FIRST=1, sr_val=16'hA5C3 -> 16 pad clk rising edges with mosi sampled 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; then RCLK high for 1 tick; sr_rdy returns high after LATCH + 8 SENSE ticks + PAUSE.
- Bit order: MSB_FIRST=0, sr_val=16'h0001 -> first mosi bit 1, remaining 15 bits 0.
- Button debounce: rclk_i held low across 2 sense cycles (DEB_CNT=2) -> btn_stb at cycle 1 with btn_val=0; at cycle 2 btn_val=1 with a btn_press pulse. Release for 2 cycles -> btn_release pulse.
- Threshold: exactly 4 high samples, then 3 high samples, each for 2 cycles -> first pattern gives raw not-pressed, second gives raw pressed.
- Arbitration: sr_go and spi_req asserted in the same IDLE cycle -> shift runs first, spi_gnt stays 0; after PAUSE, spi_gnt rises 2 cycles later and pad_o mirrors spi_o; dropping spi_req -> gnt falls 1 cycle later.
- Refresh and reset: REFRESH_LOG2=8, no sr_go -> a shift of sr_last every 256 cycles. rst asserted mid-SHIFT_HI -> next cycle state IDLE, pad clk=0, csn=1, btn_val=0.
